// File: rtl/johnson_sequence_monitor_pkg.sv
// Shared definitions for consumers of the 8-bit Johnson counter bus.
package johnson_sequence_monitor_pkg;

    localparam int unsigned JOHNSON_W   = 8;
    localparam int unsigned PHASE_COUNT = 16;
    localparam int unsigned PHASE_W     = 4;

    localparam logic [JOHNSON_W-1:0] RESET_CODE = 8'b1000_0000;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef struct packed {
        logic   legal;
        phase_t phase;
    } decode_t;

    // How a qualified sample relates to the previously accepted phase.
    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_FIRST,
        CLS_STEP,
        CLS_STALL,
        CLS_SKIP
    } sample_class_e;

    // Ones-then-zeros codes map to phases 0..7, zeros-then-ones to 8..15.
    function automatic decode_t johnson_decode(input logic [JOHNSON_W-1:0] code);
        decode_t                res;
        logic [JOHNSON_W-1:0]   all_ones;
        res      = '0;
        all_ones = '1;
        for (int unsigned k = 1; k <= JOHNSON_W; k++) begin
            if (code == (all_ones << (JOHNSON_W - k))) begin
                res.legal = 1'b1;
                res.phase = phase_t'(k - 1);
            end
            if (code == (all_ones >> k)) begin
                res.legal = 1'b1;
                res.phase = phase_t'(k + JOHNSON_W - 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/johnson_sequence_monitor_if.sv
// Sample/status bus between a Johnson counter consumer and its user.
interface johnson_sequence_monitor_if
    import johnson_sequence_monitor_pkg::*;
#(
    parameter int unsigned REV_W = 16,
    parameter int unsigned ERR_W = 8
);
    logic                  Enable_In;
    logic                  Clear_In;
    logic [JOHNSON_W-1:0]  Count_In;
    phase_t                Phase_Out;
    logic                  Phase_Valid_Out;
    logic                  Step_Out;
    logic                  Wrap_Out;
    logic                  Stall_Out;
    logic                  Stuck_Out;
    logic [REV_W-1:0]      Rev_Count_Out;
    logic                  Err_Illegal_Out;
    logic                  Err_Skip_Out;
    logic [ERR_W-1:0]      Err_Count_Out;

    modport master (
        output Enable_In, Clear_In, Count_In,
        input  Phase_Out, Phase_Valid_Out, Step_Out, Wrap_Out, Stall_Out,
               Stuck_Out, Rev_Count_Out, Err_Illegal_Out, Err_Skip_Out,
               Err_Count_Out
    );

    modport slave (
        input  Enable_In, Clear_In, Count_In,
        output Phase_Out, Phase_Valid_Out, Step_Out, Wrap_Out, Stall_Out,
               Stuck_Out, Rev_Count_Out, Err_Illegal_Out, Err_Skip_Out,
               Err_Count_Out
    );
endinterface

// File: rtl/johnson_phase_decode.sv
// Combinational Johnson code to phase index decoder.
module johnson_phase_decode
    import johnson_sequence_monitor_pkg::*;
(
    input  logic [JOHNSON_W-1:0] count,
    output logic                 legal,
    output phase_t               phase
);
    decode_t res;

    // Decode the code and flag the 240 non-Johnson patterns.
    always_comb begin
        res   = johnson_decode(count);
        legal = res.legal;
        phase = res.phase;
    end
endmodule

// File: rtl/johnson_sequence_monitor.sv
// Sequence integrity checker and revolution counter for an 8-bit Johnson bus.
module johnson_sequence_monitor
    import johnson_sequence_monitor_pkg::*;
#(
    parameter int unsigned REV_W       = 16,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned STALL_LIMIT = 4
)(
    input  logic                        Clk_In,
    input  logic                        Reset_In,
    johnson_sequence_monitor_if.slave   bus
);
    localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

    logic          dec_legal;
    phase_t        dec_phase;
    phase_t        phase_q;
    phase_t        phase_inc;
    logic          valid_q;
    logic          step_q;
    logic          wrap_q;
    logic          stall_q;
    logic          have_last_q;
    logic          ill_q;
    logic          skip_q;
    logic [REV_W-1:0] rev_q;
    logic [REV_W-1:0] rev_next;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_next;
    logic [7:0]    stall_cnt_q;
    logic [7:0]    stall_next;
    sample_class_e cls;

    johnson_phase_decode u_decode (
        .count (bus.Count_In),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    // Classify the current sample and precompute saturating increments.
    always_comb begin
        phase_inc  = phase_q + 4'd1;
        rev_next   = (rev_q == '1) ? rev_q : rev_q + REV_W'(1);
        err_next   = (err_q == '1) ? err_q : err_q + ERR_W'(1);
        stall_next = (stall_cnt_q >= STALL_MAX) ? STALL_MAX : stall_cnt_q + 8'd1;
        cls        = CLS_ILLEGAL;
        if (dec_legal) begin
            if (!have_last_q)
                cls = CLS_FIRST;
            else if (dec_phase == phase_inc)
                cls = CLS_STEP;
            else if (dec_phase == phase_q)
                cls = CLS_STALL;
            else
                cls = CLS_SKIP;
        end
    end

    // Sequence state: clear beats enable-low, which beats sampling.
    // phase_q doubles as the comparison reference; have_last_q qualifies it.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            phase_q     <= '0;
            valid_q     <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            stall_q     <= 1'b0;
            have_last_q <= 1'b0;
            ill_q       <= 1'b0;
            skip_q      <= 1'b0;
            rev_q       <= '0;
            err_q       <= '0;
            stall_cnt_q <= '0;
        end else if (bus.Clear_In) begin
            valid_q     <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            stall_q     <= 1'b0;
            have_last_q <= 1'b0;
            ill_q       <= 1'b0;
            skip_q      <= 1'b0;
            rev_q       <= '0;
            err_q       <= '0;
            stall_cnt_q <= '0;
        end else if (!bus.Enable_In) begin
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            stall_q <= 1'b0;
            case (cls)
                CLS_ILLEGAL: begin
                    valid_q     <= 1'b0;
                    ill_q       <= 1'b1;
                    err_q       <= err_next;
                    have_last_q <= 1'b0;
                    stall_cnt_q <= '0;
                end
                CLS_FIRST: begin
                    phase_q     <= dec_phase;
                    valid_q     <= 1'b1;
                    have_last_q <= 1'b1;
                end
                CLS_STEP: begin
                    phase_q     <= dec_phase;
                    valid_q     <= 1'b1;
                    step_q      <= 1'b1;
                    stall_cnt_q <= '0;
                    if (phase_q == phase_t'(PHASE_COUNT - 1)) begin
                        wrap_q <= 1'b1;
                        rev_q  <= rev_next;
                    end
                end
                CLS_STALL: begin
                    stall_q     <= 1'b1;
                    stall_cnt_q <= stall_next;
                end
                CLS_SKIP: begin
                    phase_q     <= dec_phase;
                    valid_q     <= 1'b1;
                    skip_q      <= 1'b1;
                    err_q       <= err_next;
                    stall_cnt_q <= '0;
                end
                default: begin
                    stall_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.Phase_Out       = phase_q;
    assign bus.Phase_Valid_Out = valid_q;
    assign bus.Step_Out        = step_q;
    assign bus.Wrap_Out        = wrap_q;
    assign bus.Stall_Out       = stall_q;
    assign bus.Stuck_Out       = (stall_cnt_q == STALL_MAX);
    assign bus.Rev_Count_Out   = rev_q;
    assign bus.Err_Illegal_Out = ill_q;
    assign bus.Err_Skip_Out    = skip_q;
    assign bus.Err_Count_Out   = err_q;
endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// Randomised self-checking bench for johnson_sequence_monitor (wide and 2-bit counter instances).
module tb_johnson_sequence_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    johnson_sequence_monitor_if #(.REV_W(16), .ERR_W(8)) bus_a ();
    johnson_sequence_monitor_if #(.REV_W(2),  .ERR_W(2)) bus_b ();

    johnson_sequence_monitor #(.REV_W(16), .ERR_W(8), .STALL_LIMIT(4)) dut_a (
        .Clk_In(clk), .Reset_In(rst), .bus(bus_a.slave));
    johnson_sequence_monitor #(.REV_W(2), .ERR_W(2), .STALL_LIMIT(4)) dut_b (
        .Clk_In(clk), .Reset_In(rst), .bus(bus_b.slave));

    // Legal codes in counting order, produced by running a Johnson counter.
    logic [7:0] jtab [16];

    // Reference model: unbounded counts, saturation applied on compare.
    int   m_phase, m_stalls, m_rev, m_err;
    logic m_have, m_valid, m_step, m_wrap, m_stall, m_ill, m_skip;

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < 16; i++)
            if (jtab[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] c;
        do c = 8'($urandom); while (lookup(c) >= 0);
        return c;
    endfunction

    function automatic int sat(input int v, input int cap);
        return (v < cap) ? v : cap;
    endfunction

    function automatic logic [38:0] model_vec();
        return {4'(m_phase), m_valid, m_step, m_wrap, m_stall, (m_stalls >= 4), m_ill, m_skip,
                16'(sat(m_rev, 65535)), 8'(sat(m_err, 255)), 2'(sat(m_rev, 3)), 2'(sat(m_err, 3))};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {bus_a.Phase_Out, bus_a.Phase_Valid_Out, bus_a.Step_Out, bus_a.Wrap_Out,
                bus_a.Stall_Out, bus_a.Stuck_Out, bus_a.Err_Illegal_Out, bus_a.Err_Skip_Out,
                bus_a.Rev_Count_Out, bus_a.Err_Count_Out, bus_b.Rev_Count_Out, bus_b.Err_Count_Out};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_stalls = 0; m_rev = 0; m_err = 0;
        m_have = 0; m_valid = 0; m_step = 0; m_wrap = 0; m_stall = 0; m_ill = 0; m_skip = 0;
    endtask

    task automatic model_update(input logic en, input logic clr, input logic [7:0] code);
        int idx;
        m_step = 0; m_wrap = 0; m_stall = 0;
        if (clr) begin
            m_rev = 0; m_err = 0; m_ill = 0; m_skip = 0; m_have = 0; m_stalls = 0; m_valid = 0;
        end else if (en) begin
            idx = lookup(code);
            if (idx < 0) begin
                m_valid = 0; m_ill = 1; m_err++; m_have = 0; m_stalls = 0;
            end else if (!m_have) begin
                m_phase = idx; m_valid = 1; m_have = 1;
            end else if (idx == (m_phase + 1) % 16) begin
                m_step = 1; m_stalls = 0;
                if (m_phase == 15) begin m_wrap = 1; m_rev++; end
                m_phase = idx;
            end else if (idx == m_phase) begin
                m_stall = 1; m_stalls++;
            end else begin
                m_skip = 1; m_err++; m_stalls = 0; m_phase = idx;
            end
        end
    endtask

    // Drive one sample onto both instances; returns 1 time unit after the edge.
    task automatic cycle(input logic en, input logic clr, input logic [7:0] code);
        bus_a.Enable_In = en;  bus_b.Enable_In = en;
        bus_a.Clear_In  = clr; bus_b.Clear_In  = clr;
        bus_a.Count_In  = code; bus_b.Count_In = code;
        @(posedge clk);
        model_update(en, clr, code);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (dut_vec() !== 39'b0) begin
            $display("FAIL reset_state: got %h want %h", dut_vec(), 39'b0); bad++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i <= 16; i++) begin
            cycle(1'b1, 1'b0, jtab[i % 16]);
            total++;
            if ({bus_a.Phase_Out, bus_a.Step_Out, bus_a.Wrap_Out} !== {4'(i % 16), (i >= 1), (i == 16)}) begin
                $display("FAIL sweep_%0d: got ph=%0d st=%b wr=%b want ph=%0d st=%b wr=%b", i,
                         bus_a.Phase_Out, bus_a.Step_Out, bus_a.Wrap_Out, i % 16, (i >= 1), (i == 16));
                bad++;
            end
            total++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL sweep_model_%0d: got %h want %h", i, dut_vec(), model_vec()); bad++;
            end
        end
        total++;
        if ({bus_a.Rev_Count_Out, bus_a.Err_Count_Out, bus_a.Err_Illegal_Out, bus_a.Err_Skip_Out} !== {16'd1, 8'd0, 2'b00}) begin
            $display("FAIL sweep_rev: got rev=%0d err=%0d want rev=1 err=0", bus_a.Rev_Count_Out, bus_a.Err_Count_Out); bad++;
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'b1100_0000);
        for (int j = 0; j < 6; j++) begin
            cycle(1'b1, 1'b0, 8'b1110_0000);
            total++;
            if ({bus_a.Phase_Out, bus_a.Stall_Out, bus_a.Stuck_Out} !== {4'd2, (j >= 1), (j >= 4)}) begin
                $display("FAIL stall_%0d: got ph=%0d stall=%b stuck=%b want ph=2 stall=%b stuck=%b", j,
                         bus_a.Phase_Out, bus_a.Stall_Out, bus_a.Stuck_Out, (j >= 1), (j >= 4));
                bad++;
            end
        end
        cycle(1'b1, 1'b0, 8'b1111_0000);
        total++;
        if ({bus_a.Step_Out, bus_a.Stuck_Out, bus_a.Stall_Out} !== 3'b100) begin
            $display("FAIL stall_release: got step=%b stuck=%b stall=%b want 1 0 0",
                     bus_a.Step_Out, bus_a.Stuck_Out, bus_a.Stall_Out);
            bad++;
        end
    endtask

    task automatic test_illegal();
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'b1100_0000);
        cycle(1'b1, 1'b0, 8'b1010_0000);
        total++;
        if ({bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Err_Illegal_Out, bus_a.Err_Count_Out} !== {1'b0, 4'd1, 1'b1, 8'd1}) begin
            $display("FAIL illegal: got v=%b ph=%0d ill=%b err=%0d want v=0 ph=1 ill=1 err=1",
                     bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Err_Illegal_Out, bus_a.Err_Count_Out);
            bad++;
        end
        cycle(1'b1, 1'b0, 8'b1111_0000);
        total++;
        if ({bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Err_Skip_Out, bus_a.Step_Out} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
            $display("FAIL illegal_resync: got v=%b ph=%0d skip=%b step=%b want v=1 ph=3 skip=0 step=0",
                     bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Err_Skip_Out, bus_a.Step_Out);
            bad++;
        end
    endtask

    task automatic test_skip();
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'b1100_0000);
        cycle(1'b1, 1'b0, 8'b1111_0000);
        total++;
        if ({bus_a.Err_Skip_Out, bus_a.Err_Count_Out, bus_a.Phase_Out, bus_a.Step_Out} !== {1'b1, 8'd1, 4'd3, 1'b0}) begin
            $display("FAIL skip: got skip=%b err=%0d ph=%0d step=%b want skip=1 err=1 ph=3 step=0",
                     bus_a.Err_Skip_Out, bus_a.Err_Count_Out, bus_a.Phase_Out, bus_a.Step_Out);
            bad++;
        end
        cycle(1'b1, 1'b0, 8'b1111_1000);
        total++;
        if ({bus_a.Step_Out, bus_a.Phase_Out} !== {1'b1, 4'd4}) begin
            $display("FAIL skip_follow: got step=%b ph=%0d want step=1 ph=4", bus_a.Step_Out, bus_a.Phase_Out); bad++;
        end
    endtask

    task automatic test_clear();
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'b1010_0000);
        cycle(1'b1, 1'b0, 8'b1100_0000);
        cycle(1'b1, 1'b0, 8'b1110_0000);
        cycle(1'b1, 1'b1, 8'b1111_0000);
        total++;
        if (dut_vec() !== {4'd2, 35'b0}) begin
            $display("FAIL clear: got %h want %h", dut_vec(), {4'd2, 35'b0}); bad++;
        end
        cycle(1'b1, 1'b0, 8'b1111_0000);
        total++;
        if ({bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Step_Out, bus_a.Err_Skip_Out} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
            $display("FAIL clear_first: got v=%b ph=%0d step=%b skip=%b want v=1 ph=3 step=0 skip=0",
                     bus_a.Phase_Valid_Out, bus_a.Phase_Out, bus_a.Step_Out, bus_a.Err_Skip_Out);
            bad++;
        end
    endtask

    task automatic test_enable();
        cycle(1'b1, 1'b0, 8'b1111_1000);
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 1'b0, 8'($urandom));
            total++;
            if (dut_vec() !== model_vec() || bus_a.Phase_Out !== 4'd4 || bus_a.Step_Out !== 1'b0) begin
                $display("FAIL enable_hold_%0d: got %h want %h", j, dut_vec(), model_vec()); bad++;
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b1, 8'h00);
        for (int j = 0; j < 5; j++) cycle(1'b1, 1'b0, rand_illegal());
        total++;
        if ({bus_a.Err_Count_Out, bus_b.Err_Count_Out} !== {8'd5, 2'd3}) begin
            $display("FAIL err_sat: got a=%0d b=%0d want a=5 b=3", bus_a.Err_Count_Out, bus_b.Err_Count_Out); bad++;
        end
        cycle(1'b1, 1'b1, 8'h00);
        for (int j = 0; j <= 80; j++) cycle(1'b1, 1'b0, jtab[j % 16]);
        total++;
        if ({bus_a.Rev_Count_Out, bus_b.Rev_Count_Out} !== {16'd5, 2'd3}) begin
            $display("FAIL rev_sat: got a=%0d b=%0d want a=5 b=3", bus_a.Rev_Count_Out, bus_b.Rev_Count_Out); bad++;
        end
        total++;
        if (dut_vec() !== model_vec()) begin
            $display("FAIL sat_model: got %h want %h", dut_vec(), model_vec()); bad++;
        end
    endtask

    task automatic test_random();
        logic [7:0] code;
        int         r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      code = jtab[(m_phase + 1) % 16];
            else if (r < 60) code = jtab[m_phase];
            else if (r < 72) code = jtab[$urandom_range(0, 15)];
            else if (r < 84) code = rand_illegal();
            else             code = 8'($urandom);
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), code);
            total++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random_%0d: got %h want %h", n, dut_vec(), model_vec()); bad++;
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 8'b1100_0000);
        cycle(1'b1, 1'b0, 8'b1110_0000);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_vec() !== 39'b0) begin
            $display("FAIL async_reset: got %h want %h", dut_vec(), 39'b0); bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'b1111_1111);
        total++;
        if (dut_vec() !== model_vec() || bus_a.Phase_Out !== 4'd7) begin
            $display("FAIL post_reset: got %h want %h", dut_vec(), model_vec()); bad++;
        end
    endtask

    initial begin
        logic [7:0] c;
        c = 8'b1000_0000;
        for (int i = 0; i < 16; i++) begin
            jtab[i] = c;
            c = {~c[0], c[7:1]};
        end
        bus_a.Enable_In = 1'b0; bus_b.Enable_In = 1'b0;
        bus_a.Clear_In  = 1'b0; bus_b.Clear_In  = 1'b0;
        bus_a.Count_In  = 8'h00; bus_b.Count_In = 8'h00;
        model_reset();
        test_reset();
        test_sweep();
        test_stall();
        test_illegal();
        test_skip();
        test_clear();
        test_enable();
        test_saturation();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_sequence_monitor.md
Name: johnson_sequence_monitor

Overview:
- Downstream consumer of the 8-bit Johnson counter; samples its Count_Out bus and decodes it to a 4-bit phase index (0..15).
- Checks sequence integrity and flags illegal codes, skipped phases, and stuck counts.
- Counts completed revolutions for timing/diagnostic logic.
- Samples on the rising edge; the producer updates on the falling edge, so the bus is stable half a cycle before sampling.

Parameters:
- REV_W, 16, width of revolution counter; saturating.
- ERR_W, 8, width of error event counter; saturating.
- STALL_LIMIT, 4, consecutive stall samples before Stuck_Out asserts; legal range 1..255.

Ports:
- Clk_In  input  1  single clock; all state updates on posedge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  sample qualifier; 0 = hold all state, pulses low.
- Clear_In  input  1  synchronous clear of counters, sticky errors and history.
- Count_In  input  8  Johnson code from counter.
- Phase_Out  output  4  last legal decoded phase.
- Phase_Valid_Out  output  1  1 = last sample was a legal code.
- Step_Out  output  1  pulse: phase advanced by exactly +1 mod 16.
- Wrap_Out  output  1  pulse: step from 15 to 0.
- Stall_Out  output  1  pulse: phase equal to previous phase.
- Stuck_Out  output  1  level: consecutive stalls >= STALL_LIMIT.
- Rev_Count_Out  output  REV_W  completed revolutions.
- Err_Illegal_Out  output  1  sticky: illegal code seen.
- Err_Skip_Out  output  1  sticky: legal but non-adjacent phase seen.
- Err_Count_Out  output  ERR_W  illegal + skip events.

Behaviour:
- Reset (async, Reset_In=1): all outputs 0; internal Have_Last=0, Last_Phase=0, stall counter=0.
- Decode (combinational):
  - k leading ones then zeros (k=1..8) -> phase k-1.
  - k leading zeros then ones (k=1..8) -> phase 7+k; 00000000 = 15.
  - The other 240 codes are illegal.
- Latency: one cycle. Outputs reflect the Count_In sampled at the previous posedge with Enable_In=1.
- Priority per posedge: Clear_In > Enable_In=0 > sample.
  - Clear_In=1: counters, sticky errors, Have_Last, stall counter, pulses and Phase_Valid_Out all go to 0. Phase_Out holds. The concurrent sample is discarded.
  - Enable_In=0: Step/Wrap/Stall pulses go to 0; all other state holds.
- Legal sample with Have_Last=0: Phase_Out=phase, Phase_Valid_Out=1, Have_Last=1, no pulses, no error.
- Legal sample with Have_Last=1, comparing against Last_Phase:
  - new==last+1 mod 16: Step_Out=1 and stall counter=0. If last==15, Wrap_Out=1 and Rev_Count_Out increments, saturating at all-ones.
  - new==last: Stall_Out=1; stall counter increments, saturating at STALL_LIMIT.
  - Otherwise: Err_Skip_Out=1 (sticky), Err_Count_Out+1 (saturating), stall counter=0. Phase is accepted, so the next sample is compared against the new phase.
- Illegal sample:
  - Phase_Valid_Out=0 and Phase_Out holds.
  - Err_Illegal_Out=1 (sticky), Err_Count_Out+1 (saturating).
  - Have_Last=0 (resynchronise) and stall counter=0.
  - No pulses.
- Stuck_Out = (stall counter == STALL_LIMIT). It is registered with the sample and drops on the cycle any step, skip, illegal or clear is processed.
- Pulses are high for exactly one cycle per qualifying sample.
- Reset mid-operation: immediate return to reset values regardless of clock.

Decomposition:
- Shared package:
  - Phase type (4 bits).
  - Johnson width constant 8 and phase count 16.
  - Reset code constant 8'b10000000.
  - Decode function returning {legal, phase}.
- One combinational sub-module, johnson_phase_decode (Count_In -> legal, phase), reused by other Johnson consumers.
- The sequence checker, counters and stall logic stay in the top.

Test Plan:
- Reset, Enable=1, drive 10000000, 11000000 ... 11111111, 01111111 ... 00000000, 10000000 (17 samples):
  - Phase_Out follows 0..15, 0 one cycle later.
  - Step_Out on samples 2..17; Wrap_Out only on the last.
  - Rev_Count_Out=1; no errors.
- Hold 11100000 for 6 samples with STALL_LIMIT=4 -> Phase_Out=2, Stall_Out on samples 2..6, Stuck_Out from sample 5. Then 11110000 -> Step_Out=1, Stuck_Out=0.
- After phase 1, drive 10100000 -> Phase_Valid_Out=0, Phase_Out=1, Err_Illegal_Out=1, Err_Count_Out=1. Then 11110000 -> Phase_Out=3, Phase_Valid_Out=1, no skip error, no Step_Out.
- Phase 1 then 11110000 -> Err_Skip_Out=1, Err_Count_Out increments, Phase_Out=3, Step_Out=0. Then 11111000 -> Step_Out=1.
- Clear_In=1 together with a legal step sample -> all counters, sticky errors and pulses 0, Phase_Out held. Next sample sets Have_Last without a Step.
- Saturation and reset:
  - ERR_W=2: feed 5 illegal codes -> Err_Count_Out=3.
  - REV_W=2: 5 revolutions -> Rev_Count_Out=3.
  - Assert Reset_In between clock edges -> outputs 0 before the next edge.
